// File: rtl/fpu_result_arbiter.sv
// fpu_result_arbiter
//   Two-requester round-robin arbiter that packs the granted FPU result
//   into IEEE754 form and holds it in a single output register.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   reqN_valid / reqN_ready     per-requester handshake (N = 0, 1)
//   reqN_mode                   0 = single (low 32 bits), 1 = double
//   reqN_sign/exp/man           raw sign, biased exponent, mantissa
//   reqN_nan/inf/err            special-value flags and error flag
//   out_valid / out_ready       output handshake
//   out_data                    packed 64-bit result
//   out_err, out_src            error flag and requester index of held result
//   grant_cnt0/1                per-requester saturating transfer counters,
//                               present only with FPU_ARB_STATS_EN defined
//
// Configuration macro: FPU_ARB_STATS_EN
module fpu_result_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mode,
  input  logic        req0_sign,
  input  logic [10:0] req0_exp,
  input  logic [51:0] req0_man,
  input  logic        req0_nan,
  input  logic        req0_inf,
  input  logic        req0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mode,
  input  logic        req1_sign,
  input  logic [10:0] req1_exp,
  input  logic [51:0] req1_man,
  input  logic        req1_nan,
  input  logic        req1_inf,
  input  logic        req1_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err,
  output logic        out_src
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;
  logic        src_q, src_d;
  logic        last_q, last_d;   // index of the most recently granted requester
  logic        accept_ok;
  logic        gnt0, gnt1;

  function automatic logic [63:0] pack(input logic        mode,
                                       input logic        sign,
                                       input logic [10:0] e,
                                       input logic [51:0] m,
                                       input logic        nan,
                                       input logic        inf);
    logic [63:0] r;
    if (nan)
      r = mode ? {sign, 11'h7FF, 52'd1} : {32'b0, sign, 8'hFF, 23'd1};
    else if (inf)
      r = mode ? {sign, 11'h7FF, 52'd0} : {32'b0, sign, 8'hFF, 23'd0};
    else
      r = mode ? {sign, e, m} : {32'b0, sign, e[7:0], m[22:0]};
    return r;
  endfunction

  assign accept_ok = (state_q == EMPTY) || out_ready;

  // Under contention the requester that did not win last time is granted.
  // Ready is gated by rst so nothing can transfer while reset is held.
  assign gnt0 = !rst && accept_ok && req0_valid && (!req1_valid || last_q);
  assign gnt1 = !rst && accept_ok && req1_valid && (!req0_valid || !last_q);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    src_d   = src_q;
    last_d  = last_q;
    if (gnt0 || gnt1) begin
      state_d = FULL;
      data_d  = gnt1 ? pack(req1_mode, req1_sign, req1_exp, req1_man, req1_nan, req1_inf)
                     : pack(req0_mode, req0_sign, req0_exp, req0_man, req0_nan, req0_inf);
      err_d   = gnt1 ? req1_err : req0_err;
      src_d   = gnt1;
      last_d  = gnt1;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      err_q   <= 1'b0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;   // requester 0 wins the first contention
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
      src_q   <= src_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign out_src   = src_q;

`ifdef FPU_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0 && cnt0_q != '1) cnt0_d = cnt0_q + 16'd1;
    if (gnt1 && cnt1_q != '1) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_fpu_result_arbiter.sv
module tb_fpu_result_arbiter;

  typedef struct packed {
    logic        mode;
    logic        sign;
    logic [10:0] exp;
    logic [51:0] man;
    logic        nan;
    logic        inf;
    logic        err;
  } req_t;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
    logic        src;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic        req0_mode = 1'b0, req0_sign = 1'b0, req0_nan = 1'b0, req0_inf = 1'b0, req0_err = 1'b0;
  logic        req1_mode = 1'b0, req1_sign = 1'b0, req1_nan = 1'b0, req1_inf = 1'b0, req1_err = 1'b0;
  logic [10:0] req0_exp = '0, req1_exp = '0;
  logic [51:0] req0_man = '0, req1_man = '0;
  logic        out_valid, out_err, out_src;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
`ifdef FPU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b1;
  res_t sb[$];

  always #5 clk = ~clk;

  fpu_result_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_sign(req0_sign), .req0_exp(req0_exp), .req0_man(req0_man),
    .req0_nan(req0_nan), .req0_inf(req0_inf), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_sign(req1_sign), .req1_exp(req1_exp), .req1_man(req1_man),
    .req1_nan(req1_nan), .req1_inf(req1_inf), .req1_err(req1_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_src(out_src)
`ifdef FPU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  // Hand-computed vectors: {mode, sign, exp, man, nan, inf, err}
  localparam req_t R_S1   = '{1'b0, 1'b1, 11'h080, 52'h400000, 1'b0, 1'b0, 1'b0};
  localparam req_t R_ONE  = '{1'b0, 1'b0, 11'h07F, 52'h0, 1'b0, 1'b0, 1'b0};
  localparam req_t R_M2   = '{1'b0, 1'b1, 11'h780, 52'hABCDEF0000000, 1'b0, 1'b0, 1'b0};
  localparam req_t R_NAND = '{1'b1, 1'b0, 11'h123, 52'h5, 1'b1, 1'b1, 1'b0};
  localparam req_t R_INFD = '{1'b1, 1'b1, 11'h001, 52'h7, 1'b0, 1'b1, 1'b1};
  localparam req_t R_D15  = '{1'b1, 1'b0, 11'h3FF, 52'h8000000000000, 1'b0, 1'b0, 1'b0};
  localparam req_t R_NANS = '{1'b0, 1'b1, 11'h000, 52'h0, 1'b1, 1'b0, 1'b0};
  localparam req_t R_GARB = '{1'b1, 1'b1, 11'h5A5, 52'hF0F0F0F0F0F0F, 1'b1, 1'b1, 1'b1};

  localparam logic [64:0] E_S1   = {64'h00000000C0400000, 1'b0};
  localparam logic [64:0] E_ONE  = {64'h000000003F800000, 1'b0};
  localparam logic [64:0] E_M2   = {64'h00000000C0000000, 1'b0};
  localparam logic [64:0] E_NAND = {64'h7FF0000000000001, 1'b0};
  localparam logic [64:0] E_INFD = {64'hFFF0000000000000, 1'b1};
  localparam logic [64:0] E_D15  = {64'h3FF8000000000000, 1'b0};
  localparam logic [64:0] E_NANS = {64'h00000000FF800001, 1'b0};
  localparam logic [64:0] E_NONE = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus: drive after the edge, check grants at the
  // falling edge and queue the expected result of whichever requester wins.
  task automatic cyc(input bit v0, input req_t r0, input logic [64:0] e0,
                     input bit v1, input req_t r1, input logic [64:0] e1,
                     input bit ordy, input int exp_g, input string nm);
    @(posedge clk);
    #1;
    req0_valid = v0;
    {req0_mode, req0_sign, req0_exp, req0_man, req0_nan, req0_inf, req0_err} = r0;
    req1_valid = v1;
    {req1_mode, req1_sign, req1_exp, req1_man, req1_nan, req1_inf, req1_err} = r1;
    out_ready = ordy;
    @(negedge clk);
    chk({nm, "_grant"}, {62'd0, req1_ready, req0_ready}, 64'(exp_g));
    if (req0_valid && req0_ready) sb.push_back('{e0[64:1], e0[0], 1'b0});
    else if (req1_valid && req1_ready) sb.push_back('{e1[64:1], e1[0], 1'b1});
  endtask

  task automatic idle(input bit ordy, input string nm);
    cyc(1'b0, R_GARB, E_NONE, 1'b0, R_GARB, E_NONE, ordy, 0, nm);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_err_src", {62'd0, out_err, out_src}, 64'd0);
    chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got data %h err %b src %b with no result expected",
                 out_data, out_err, out_src);
      end else begin
        res_t e;
        e = sb.pop_front();
        n_cmp++;
        if ({out_data, out_err, out_src} !== e) begin
          n_err++;
          $display("FAIL sb_result: got data %h err %b src %b expected data %h err %b src %b",
                   out_data, out_err, out_src, e.data, e.err, e.src);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state; a valid request must not be accepted while rst is high.
    req0_valid = 1'b1;
    #3;
    chk("init_out_valid", {63'd0, out_valid}, 64'd0);
    chk("init_out_data", out_data, 64'd0);
    chk("init_ready_in_rst", {62'd0, req1_ready, req0_ready}, 64'd0);
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-precision packing with latency 1, then FULL -> EMPTY.
    cyc(1'b1, R_S1, E_S1, 1'b0, R_GARB, E_NONE, 1'b1, 1, "s1");
    idle(1'b1, "s1_drain");
    chk("s1_latency_valid", {63'd0, out_valid}, 64'd1);
    idle(1'b1, "s1_empty");
    chk("s1_empty", {63'd0, out_valid}, 64'd0);

    // Continuous contention after reset alternates starting with req0.
    do_reset();
    cyc(1'b1, R_ONE, E_ONE, 1'b1, R_M2, E_M2, 1'b1, 1, "rr0");
    cyc(1'b1, R_ONE, E_ONE, 1'b1, R_M2, E_M2, 1'b1, 2, "rr1");
    cyc(1'b1, R_ONE, E_ONE, 1'b1, R_M2, E_M2, 1'b1, 1, "rr2");
    cyc(1'b1, R_ONE, E_ONE, 1'b1, R_M2, E_M2, 1'b1, 2, "rr3");
    idle(1'b1, "rr_drain");

    // NaN beats Inf in double mode; result held through a 3-cycle stall.
    cyc(1'b1, R_NAND, E_NAND, 1'b0, R_GARB, E_NONE, 1'b0, 1, "nan_acc");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, R_NAND, E_NAND, 1'b0, R_GARB, E_NONE, 1'b0, 0, "nan_stall");
      chk("stall_data", out_data, 64'h7FF0000000000001);
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
    end
    idle(1'b1, "nan_release");
    idle(1'b1, "nan_empty");
    chk("nan_empty", {63'd0, out_valid}, 64'd0);

    // Back-to-back transfers under continuous out_ready.
    cyc(1'b0, R_GARB, E_NONE, 1'b1, R_INFD, E_INFD, 1'b1, 2, "infd");
    cyc(1'b1, R_D15, E_D15, 1'b0, R_GARB, E_NONE, 1'b1, 1, "d15");
    cyc(1'b0, R_GARB, E_NONE, 1'b1, R_NANS, E_NANS, 1'b1, 2, "nans");
    idle(1'b1, "b2b_drain");
    idle(1'b1, "b2b_empty");

    // Reset while FULL with requests pending; pointer would favour req1.
    cyc(1'b1, R_S1, E_S1, 1'b1, R_INFD, E_INFD, 1'b0, 1, "pre_rst");
    cyc(1'b1, R_S1, E_S1, 1'b1, R_INFD, E_INFD, 1'b0, 0, "pre_rst_stall");
    chk("pre_rst_data", out_data, 64'h00000000C0400000);
    do_reset();
    cyc(1'b1, R_ONE, E_ONE, 1'b1, R_M2, E_M2, 1'b1, 1, "post_rst");
    idle(1'b1, "post_rst_drain");
    idle(1'b1, "post_rst_empty");

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending results expected 0", sb.size());
    end

`ifdef FPU_ARB_STATS_EN
    do_reset();
    chk("cnt_after_rst", {32'd0, grant_cnt0, grant_cnt1}, 64'd0);
    mon_en = 1'b0;
    req0_valid = 1'b1;
    out_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("grant_cnt0_sat", {48'd0, grant_cnt0}, 64'h000000000000FFFF);
    chk("grant_cnt1", {48'd0, grant_cnt1}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
